// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer: packs RATIO FIFO words into one wide valid/ready word with lane enables and flush.
// Rev 1.0
`default_nettype none

module afifo_rd_packer #(
  parameter int W       = 8,
  parameter int RATIO   = 4,
  parameter int RD_FAST = 1
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [W-1:0]         fifo_rd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]     out_be
);

  localparam int LCW = $clog2(RATIO) + 1;
  localparam int LIW = LCW - 1;
  localparam logic [LCW-1:0] c_FULL   = LCW'(RATIO);
  localparam logic [LCW:0]   c_FULL_X = (LCW+1)'(RATIO);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_run;
  logic                      r_pend;
  logic [LCW-1:0]            r_lane_cnt;
  logic [RATIO-1:0][W-1:0]   r_asm;
  logic                      r_out_valid;
  logic [W*RATIO-1:0]        r_out_data;
  logic [RATIO-1:0]          r_out_be;

  logic                      w_out_free;
  logic                      w_xfer;
  logic [LCW:0]              w_sum;
  logic                      w_partial;
  logic                      w_rd_en;
  logic                      w_cap;
  logic                      w_flush_load;
  logic [LIW-1:0]            w_wr_lane;
  logic [RATIO-1:0]          w_part_be;
  logic [W*RATIO-1:0]        w_part_data;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_xfer     = (r_lane_cnt == c_FULL) && w_out_free;
  assign w_sum      = {1'b0, r_lane_cnt} + {{LCW{1'b0}}, r_pend};
  assign w_partial  = (w_sum != '0) && (w_sum < c_FULL_X);
  // Slow-read FIFOs deliver data the cycle after the pop, tracked by r_pend.
  assign w_cap      = (RD_FAST != 0) ? w_rd_en : r_pend;
  assign w_wr_lane  = w_xfer ? '0 : r_lane_cnt[LIW-1:0];

  generate
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      assign w_part_be[k]           = (r_lane_cnt > LCW'(k));
      assign w_part_data[k*W +: W]  = w_part_be[k] ? r_asm[k] : '0;
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_load = 1'b0;
    w_rd_en      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_rd_en = r_run && !flush && !fifo_empty && ((w_sum < c_FULL_X) || w_xfer);
        // Emit immediately when nothing is in flight; otherwise drain first.
        if (flush && w_partial) begin
          if (!r_pend && w_out_free) begin
            w_flush_load = 1'b1;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!r_pend && w_out_free) begin
          w_flush_load = 1'b1;
          w_state_nxt  = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_run       <= 1'b0;
      r_pend      <= 1'b0;
      r_lane_cnt  <= '0;
      r_asm       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_be    <= '0;
    end else begin
      r_run  <= 1'b1;
      r_pend <= (RD_FAST == 0) ? w_rd_en : 1'b0;

      if (w_cap) begin
        r_asm[w_wr_lane] <= fifo_rd_data;
      end

      if (w_xfer) begin
        r_lane_cnt <= w_cap ? LCW'(1) : '0;
      end else if (w_flush_load) begin
        r_lane_cnt <= '0;
      end else if (w_cap) begin
        r_lane_cnt <= r_lane_cnt + LCW'(1);
      end

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_asm;
        r_out_be    <= '1;
      end else if (w_flush_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_part_data;
        r_out_be    <= w_part_be;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_be     = r_out_be;

endmodule

`default_nettype wire

// File: tb/tb_afifo_rd_packer.sv
// Directed bench for afifo_rd_packer: one RD_FAST=1 and one RD_FAST=0 instance fed by simple FIFO models.
`default_nettype none

module tb_afifo_rd_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_empty, a_rd_en, a_flush, a_valid, a_ready;
  logic [7:0]  a_data;
  logic [31:0] a_out;
  logic [3:0]  a_be;
  logic        b_empty, b_rd_en, b_flush, b_valid, b_ready;
  logic [7:0]  b_data = 8'h00;
  logic [31:0] b_out;
  logic [3:0]  b_be;

  afifo_rd_packer #(.W(8), .RATIO(4), .RD_FAST(1)) u_fast (
    .rd_clk(clk), .rd_reset_n(rst_n), .fifo_empty(a_empty), .fifo_rd_en(a_rd_en),
    .fifo_rd_data(a_data), .flush(a_flush), .out_valid(a_valid), .out_ready(a_ready),
    .out_data(a_out), .out_be(a_be));

  afifo_rd_packer #(.W(8), .RATIO(4), .RD_FAST(0)) u_slow (
    .rd_clk(clk), .rd_reset_n(rst_n), .fifo_empty(b_empty), .fifo_rd_en(b_rd_en),
    .fifo_rd_data(b_data), .flush(b_flush), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_out), .out_be(b_be));

  // FIFO models: A presents data in the pop cycle, B one cycle later.
  logic [7:0] amem [0:255];
  logic [7:0] bmem [0:255];
  logic [7:0] awr = 8'd0, ard = 8'd0, bwr = 8'd0, brd = 8'd0;
  assign a_empty = (awr == ard);
  assign b_empty = (bwr == brd);
  assign a_data  = amem[ard];

  always @(posedge clk) begin
    if (a_rd_en) ard <= ard + 8'd1;
    if (b_rd_en) begin
      b_data <= bmem[brd];
      brd    <= brd + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          a_pops = 0, a_nacc = 0, a_nrise = 0, b_pops = 0, b_nacc = 0, b_nrise = 0, uflow = 0;
  logic        a_vprev = 1'b0, b_vprev = 1'b0;
  int          a_pop_cyc [0:63];
  int          a_rise_cyc [0:63];
  int          b_pop_cyc [0:63];
  int          b_rise_cyc [0:63];
  logic [31:0] a_acc_data [0:63];
  logic [3:0]  a_acc_be [0:63];
  logic [31:0] b_acc_data [0:63];
  logic [3:0]  b_acc_be [0:63];

  always @(negedge clk) begin
    if ((a_rd_en && a_empty) || (b_rd_en && b_empty)) uflow = uflow + 1;
    if (a_rd_en) begin a_pop_cyc[a_pops] = cyc; a_pops = a_pops + 1; end
    if (b_rd_en) begin b_pop_cyc[b_pops] = cyc; b_pops = b_pops + 1; end
    if (a_valid && !a_vprev) begin a_rise_cyc[a_nrise] = cyc; a_nrise = a_nrise + 1; end
    if (b_valid && !b_vprev) begin b_rise_cyc[b_nrise] = cyc; b_nrise = b_nrise + 1; end
    if (a_valid && a_ready) begin
      a_acc_data[a_nacc] = a_out; a_acc_be[a_nacc] = a_be; a_nacc = a_nacc + 1;
    end
    if (b_valid && b_ready) begin
      b_acc_data[b_nacc] = b_out; b_acc_be[b_nacc] = b_be; b_nacc = b_nacc + 1;
    end
    a_vprev = a_valid;
    b_vprev = b_valid;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] v);
    amem[awr] = v;
    awr = awr + 8'd1;
  endtask

  task automatic push_b(input logic [7:0] v);
    bmem[bwr] = v;
    bwr = bwr + 8'd1;
  endtask

  int p0, n0, q0, m0;
  logic [31:0] exp_s [0:3];
  logic [31:0] exp_bp [0:2];

  initial begin
    exp_s[0]  = 32'h53525150; exp_s[1]  = 32'h57565554;
    exp_s[2]  = 32'h5B5A5958; exp_s[3]  = 32'h5F5E5D5C;
    exp_bp[0] = 32'h63626160; exp_bp[1] = 32'h67666564; exp_bp[2] = 32'h6B6A6968;

    rst_n = 1'b0; a_flush = 1'b0; b_flush = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
    step(3); @(negedge clk);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_data", 64'(a_out), 64'd0);
    chk("rst_be", 64'(a_be), 64'd0);
    chk("rst_rd_en", 64'(a_rd_en), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);

    // Basic packing, fast read
    step(1); rst_n = 1'b1;
    step(12); @(negedge clk);
    chk("basic_pops", 64'(a_pops), 64'd4);
    chk("basic_nacc", 64'(a_nacc), 64'd1);
    chk("basic_data", 64'(a_acc_data[0]), 64'h44332211);
    chk("basic_be", 64'(a_acc_be[0]), 64'hF);
    chk("basic_latency", 64'(a_rise_cyc[0] - a_pop_cyc[0]), 64'd5);
    chk("basic_pop_span", 64'(a_pop_cyc[3] - a_pop_cyc[0]), 64'd3);

    // Streaming 16 words
    p0 = a_pops; n0 = a_nacc;
    step(1);
    for (int i = 0; i < 16; i++) push_a(8'(8'h50 + i));
    step(30); @(negedge clk);
    chk("stream_pops", 64'(a_pops - p0), 64'd16);
    chk("stream_no_bubble", 64'(a_pop_cyc[p0+15] - a_pop_cyc[p0]), 64'd15);
    chk("stream_nacc", 64'(a_nacc - n0), 64'd4);
    for (int i = 0; i < 4; i++) chk("stream_word", 64'(a_acc_data[n0+i]), 64'(exp_s[i]));
    chk("stream_underflow", 64'(uflow), 64'd0);

    // Backpressure with 12 queued words
    p0 = a_pops; n0 = a_nacc;
    step(1); a_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_a(8'(8'h60 + i));
    step(30); @(negedge clk);
    chk("bp_pops", 64'(a_pops - p0), 64'd8);
    chk("bp_rd_en", 64'(a_rd_en), 64'd0);
    chk("bp_valid", 64'(a_valid), 64'd1);
    chk("bp_data", 64'(a_out), 64'h63626160);
    step(3); @(negedge clk);
    chk("bp_stable", 64'(a_out), 64'h63626160);
    chk("bp_be", 64'(a_be), 64'hF);
    step(1); a_ready = 1'b1;
    step(20); @(negedge clk);
    chk("bp_pops_total", 64'(a_pops - p0), 64'd12);
    chk("bp_nacc", 64'(a_nacc - n0), 64'd3);
    for (int i = 0; i < 3; i++) chk("bp_word", 64'(a_acc_data[n0+i]), 64'(exp_bp[i]));

    // Flush of a two-lane partial word
    p0 = a_pops; n0 = a_nacc;
    step(1); push_a(8'hA1); push_a(8'hB2);
    step(6); @(negedge clk);
    chk("fl_pops", 64'(a_pops - p0), 64'd2);
    chk("fl_no_out_yet", 64'(a_nacc - n0), 64'd0);
    step(1); a_flush = 1'b1;
    step(1); a_flush = 1'b0;
    @(negedge clk);
    chk("fl_valid_t1", 64'(a_valid), 64'd1);
    chk("fl_data", 64'(a_out), 64'h0000B2A1);
    chk("fl_be", 64'(a_be), 64'h3);
    step(3); @(negedge clk);
    chk("fl_nacc", 64'(a_nacc - n0), 64'd1);
    step(1); a_flush = 1'b1;
    step(1); a_flush = 1'b0;
    step(4); @(negedge clk);
    chk("fl_empty_nacc", 64'(a_nacc - n0), 64'd1);
    chk("fl_empty_valid", 64'(a_valid), 64'd0);

    // Basic packing, slow read
    q0 = b_pops; m0 = b_nacc;
    step(1); push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
    step(12); @(negedge clk);
    chk("slow_pops", 64'(b_pops - q0), 64'd4);
    chk("slow_nacc", 64'(b_nacc - m0), 64'd1);
    chk("slow_data", 64'(b_acc_data[m0]), 64'h44332211);
    chk("slow_be", 64'(b_acc_be[m0]), 64'hF);
    chk("slow_latency", 64'(b_rise_cyc[b_nrise-1] - b_pop_cyc[q0]), 64'd6);

    // Slow read: flush in the cycle after the third pop
    q0 = b_pops; m0 = b_nacc;
    step(1); push_b(8'hC1); push_b(8'hC2); push_b(8'hC3);
    step(3); b_flush = 1'b1;
    step(1); b_flush = 1'b0;
    step(4); @(negedge clk);
    chk("slow_fl_pops", 64'(b_pops - q0), 64'd3);
    chk("slow_fl_nacc", 64'(b_nacc - m0), 64'd1);
    chk("slow_fl_data", 64'(b_acc_data[m0]), 64'h00C3C2C1);
    chk("slow_fl_be", 64'(b_acc_be[m0]), 64'h7);

    // Reset with a held output word and two lanes assembled
    p0 = a_pops; n0 = a_nacc;
    step(1); a_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_a(8'(8'h71 + i));
    step(15); @(negedge clk);
    chk("mr_valid_before", 64'(a_valid), 64'd1);
    chk("mr_pops_before", 64'(a_pops - p0), 64'd6);
    step(1); rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(a_valid), 64'd0);
    chk("mr_data", 64'(a_out), 64'd0);
    chk("mr_be", 64'(a_be), 64'd0);
    step(2); a_ready = 1'b1; rst_n = 1'b1;
    step(1);
    push_a(8'h81); push_a(8'h82); push_a(8'h83); push_a(8'h84);
    step(12); @(negedge clk);
    chk("mr_pops_after", 64'(a_pops - p0), 64'd10);
    chk("mr_nacc", 64'(a_nacc - n0), 64'd1);
    chk("mr_data_after", 64'(a_acc_data[n0]), 64'h84838281);
    chk("mr_be_after", 64'(a_acc_be[n0]), 64'hF);
    chk("final_underflow", 64'(uflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
